usb_cfg_rx: RTL and testbench

USB_CFG_RX -- requirements
Module: usb_cfg_rx

---
 rtl/usb_rx_pkg.sv | 47 ++++
 rtl/usb_rx_wdog.sv | 30 +++
 rtl/usb_cfg_rx.sv | 96 +++++++++
 tb/tb_usb_cfg_rx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the FX2 EP2 config receiver: FSM encoding, the session
// marker words and the per-state FX2 control decode.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        OE,
        READ,
        GAP,
        REL
    } state_t;

    localparam logic [15:0] SYNC_WORD   = 16'hF5A5;
    localparam logic [15:0] UNSYNC_WORD = 16'hFA5A;
    localparam int          BURST_CNT_W = 9;
    localparam logic [1:0]  EP2_ADR     = 2'b00;

    typedef struct packed {
        logic bus_req;
        logic sloe_n;
        logic slrd_n;
    } fx2_ctl_t;

    function automatic fx2_ctl_t ctl_of(input state_t s);
        case (s)
            REQ:     return '{bus_req: 1'b1, sloe_n: 1'b1, slrd_n: 1'b1};
            OE, GAP: return '{bus_req: 1'b1, sloe_n: 1'b0, slrd_n: 1'b1};
            READ:    return '{bus_req: 1'b1, sloe_n: 1'b0, slrd_n: 1'b0};
            default: return '{bus_req: 1'b0, sloe_n: 1'b1, slrd_n: 1'b1};
        endcase
    endfunction

    // stop folds burst limit and session timeout into one "leave after this GAP" request.
    function automatic state_t next_state(input state_t s, input logic avail,
                                          input logic gnt, input logic stop);
        case (s)
            IDLE:    return avail ? REQ : IDLE;
            REQ:     return gnt ? OE : REQ;
            OE:      return gnt ? READ : REL;
            READ:    return GAP;
            GAP:     return (gnt && avail && !stop) ? READ : REL;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/usb_rx_wdog.sv
// Config-session idle watchdog; exists only when USB_RX_TIMEOUT_EN is defined.
// expired rises TIMEOUT cycles after the last kick while active stays high.
`ifdef USB_RX_TIMEOUT_EN
module usb_rx_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic usb_clk,
    input  logic usb_rst,
    input  logic active,
    input  logic kick,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge usb_clk or posedge usb_rst) begin
        if (usb_rst) begin
            count <= '0;
        end else if (!active || kick || expired) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign expired = active && (count == W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/usb_cfg_rx.sv
// FX2 EP2 OUT reader feeding cfg one word at a time, sharing the FD bus by grant.
// Optional session idle timeout is built in with USB_RX_TIMEOUT_EN.
module usb_cfg_rx
    import usb_rx_pkg::*;
#(
    parameter int MAX_BURST = 256,
    parameter int TIMEOUT   = 1024
) (
    input  logic        usb_clk,
    input  logic        usb_rst,
    input  logic        usb_flag_empty_n,
    input  logic [15:0] usb_fd_in,
    output logic        usb_slrd_n,
    output logic        usb_sloe_n,
    output logic [1:0]  usb_fifoadr,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        usb_en,
    output logic        usb_wr,
    output logic [15:0] usb_data,
    output logic        cfg_session
);
    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);

    if (MAX_BURST < 1 || MAX_BURST > 511 || TIMEOUT < 1) begin : g_bad_param
        $error("usb_cfg_rx: MAX_BURST must be 1..511 and TIMEOUT at least 1");
    end

    state_t                 state;
    fx2_ctl_t               ctl;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic                   timeout;
    logic                   stop;

`ifdef USB_RX_TIMEOUT_EN
    usb_rx_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .usb_clk (usb_clk),
        .usb_rst (usb_rst),
        .active  (cfg_session),
        .kick    (usb_en),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // A running session keeps the grant: the burst limit only applies outside it.
    assign stop = ((burst_cnt == BURST_LIMIT) && !cfg_session) || timeout;

    assign usb_fifoadr = EP2_ADR;
    assign bus_req     = ctl.bus_req;
    assign usb_sloe_n  = ctl.sloe_n;
    assign usb_slrd_n  = ctl.slrd_n;

    // NOTE: non-blocking assignments only; strobes are decoded from the next state so they are registered.
    always_ff @(posedge usb_clk or posedge usb_rst) begin
        if (usb_rst) begin
            state <= IDLE;
            ctl   <= ctl_of(IDLE);
        end else begin
            state <= next_state(state, usb_flag_empty_n, bus_gnt, stop);
            ctl   <= ctl_of(next_state(state, usb_flag_empty_n, bus_gnt, stop));
        end
    end

    always_ff @(posedge usb_clk or posedge usb_rst) begin
        if (usb_rst) begin
            usb_en      <= 1'b0;
            usb_wr      <= 1'b0;
            usb_data    <= '0;
            cfg_session <= 1'b0;
            burst_cnt   <= '0;
        end else begin
            usb_en <= (state == READ);
            if (state == READ) begin
                usb_data <= usb_fd_in;
                usb_wr   <= 1'b1;
                if (burst_cnt != BURST_LIMIT) begin
                    burst_cnt <= burst_cnt + BURST_CNT_W'(1);
                end
            end
            if (state == REL) begin
                usb_wr    <= 1'b0;
                burst_cnt <= '0;
            end
            // Session rises with the F5A5 strobe and falls after the FA5A strobe.
            if (timeout || (usb_en && usb_data == UNSYNC_WORD)) begin
                cfg_session <= 1'b0;
            end
            if (state == READ && usb_fd_in == SYNC_WORD) begin
                cfg_session <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_cfg_rx.sv
// Directed bench for usb_cfg_rx: per-cycle vector table plus FX2 FIFO model sequences.
// Define USB_RX_TIMEOUT_EN to exercise the session timeout with TIMEOUT=16.
module tb_usb_cfg_rx;
    import usb_rx_pkg::*;

`ifdef USB_RX_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 1024;
`endif
    localparam int MAX_BURST = 256;

    logic        usb_clk = 1'b0;
    logic        usb_rst = 1'b1;
    logic        usb_flag_empty_n = 1'b0;
    logic [15:0] usb_fd_in = 16'h0000;
    logic        bus_gnt = 1'b0;
    logic        usb_slrd_n, usb_sloe_n, bus_req, usb_en, usb_wr, cfg_session;
    logic [1:0]  usb_fifoadr;
    logic [15:0] usb_data;

    usb_cfg_rx #(.MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
        .usb_clk          (usb_clk),
        .usb_rst          (usb_rst),
        .usb_flag_empty_n (usb_flag_empty_n),
        .usb_fd_in        (usb_fd_in),
        .usb_slrd_n       (usb_slrd_n),
        .usb_sloe_n       (usb_sloe_n),
        .usb_fifoadr      (usb_fifoadr),
        .bus_req          (bus_req),
        .bus_gnt          (bus_gnt),
        .usb_en           (usb_en),
        .usb_wr           (usb_wr),
        .usb_data         (usb_data),
        .cfg_session      (cfg_session)
    );

    always #5 usb_clk = ~usb_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Vector outputs packed as {bus_req, sloe_n, slrd_n, en, wr, session, data}.
    typedef struct {
        logic        flag;
        logic        gnt;
        logic [15:0] fd;
        logic [21:0] exp;
    } vec_t;

    function automatic logic [21:0] outs(input logic req, input logic oe_n, input logic rd_n,
                                         input logic en, input logic wr, input logic ses,
                                         input logic [15:0] data);
        return {req, oe_n, rd_n, en, wr, ses, data};
    endfunction

    // FX2 FIFO model and stream scoreboard.
    logic [15:0] fifo_q[$];
    logic [15:0] sent[$];
    bit          rd_seen = 1'b0;
    int          pulses, pulse_bad, sess_bad, grants, drop_pulses;
    logic        prev_req, exp_sess;

    task automatic reset_tracking();
        pulses      = 0;
        pulse_bad   = 0;
        sess_bad    = 0;
        grants      = 0;
        drop_pulses = -1;
        prev_req    = bus_req;
        exp_sess    = cfg_session;
    endtask

    // One cycle: pop after a completed read strobe, score outputs, redrive flag/data.
    task automatic step();
        @(negedge usb_clk);
        if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
        rd_seen = !usb_slrd_n;
        if (usb_en) begin
            if (usb_data == SYNC_WORD) exp_sess = 1'b1;
            if (pulses >= sent.size() || usb_data !== sent[pulses] || !usb_wr) pulse_bad++;
            pulses++;
        end
        if (cfg_session !== exp_sess) sess_bad++;
        if (usb_en && usb_data == UNSYNC_WORD) exp_sess = 1'b0;
        if (bus_req && !prev_req) grants++;
        if (!bus_req && prev_req && drop_pulses < 0) drop_pulses = pulses;
        prev_req = bus_req;
        usb_flag_empty_n = (fifo_q.size() > 0);
        usb_fd_in = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int cyc;
        cyc = 0;
        while (!(pulses >= n && !bus_req) && cyc < budget) begin
            step();
            cyc++;
        end
        check({name, "_in_budget"}, 32'(cyc < budget), 1);
    endtask

    task automatic push(input logic [15:0] w);
        fifo_q.push_back(w);
        sent.push_back(w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_slrd_n"}, usb_slrd_n, 1);
        check({tag, "_sloe_n"}, usb_sloe_n, 1);
        check({tag, "_bus_req"}, bus_req, 0);
        check({tag, "_usb_en"}, usb_en, 0);
        check({tag, "_usb_wr"}, usb_wr, 0);
        check({tag, "_usb_data"}, usb_data, 16'h0000);
        check({tag, "_cfg_session"}, cfg_session, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired required finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t vecs[21];
        int   reads;
        int   lat;
        int   cyc;

        // Single word, grant wait, grant loss in OE, then a two-word session.
        vecs[0]  = '{1'b1, 1'b1, 16'h1234, outs(1, 1, 1, 0, 0, 0, 16'h0000)};
        vecs[1]  = '{1'b1, 1'b1, 16'h1234, outs(1, 0, 1, 0, 0, 0, 16'h0000)};
        vecs[2]  = '{1'b1, 1'b1, 16'h1234, outs(1, 0, 0, 0, 0, 0, 16'h0000)};
        vecs[3]  = '{1'b0, 1'b1, 16'h1234, outs(1, 0, 1, 1, 1, 0, 16'h1234)};
        vecs[4]  = '{1'b0, 1'b1, 16'h0000, outs(0, 1, 1, 0, 1, 0, 16'h1234)};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, outs(0, 1, 1, 0, 0, 0, 16'h1234)};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, outs(0, 1, 1, 0, 0, 0, 16'h1234)};
        vecs[7]  = '{1'b1, 1'b0, 16'hABCD, outs(1, 1, 1, 0, 0, 0, 16'h1234)};
        vecs[8]  = '{1'b1, 1'b0, 16'hABCD, outs(1, 1, 1, 0, 0, 0, 16'h1234)};
        vecs[9]  = '{1'b1, 1'b1, 16'hABCD, outs(1, 0, 1, 0, 0, 0, 16'h1234)};
        vecs[10] = '{1'b1, 1'b0, 16'hABCD, outs(0, 1, 1, 0, 0, 0, 16'h1234)};
        vecs[11] = '{1'b1, 1'b0, 16'hABCD, outs(0, 1, 1, 0, 0, 0, 16'h1234)};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, outs(0, 1, 1, 0, 0, 0, 16'h1234)};
        vecs[13] = '{1'b1, 1'b1, 16'hF5A5, outs(1, 1, 1, 0, 0, 0, 16'h1234)};
        vecs[14] = '{1'b1, 1'b1, 16'hF5A5, outs(1, 0, 1, 0, 0, 0, 16'h1234)};
        vecs[15] = '{1'b1, 1'b1, 16'hF5A5, outs(1, 0, 0, 0, 0, 0, 16'h1234)};
        vecs[16] = '{1'b1, 1'b1, 16'hF5A5, outs(1, 0, 1, 1, 1, 1, 16'hF5A5)};
        vecs[17] = '{1'b1, 1'b1, 16'hFA5A, outs(1, 0, 0, 0, 1, 1, 16'hF5A5)};
        vecs[18] = '{1'b0, 1'b1, 16'hFA5A, outs(1, 0, 1, 1, 1, 1, 16'hFA5A)};
        vecs[19] = '{1'b0, 1'b1, 16'h0000, outs(0, 1, 1, 0, 1, 0, 16'hFA5A)};
        vecs[20] = '{1'b0, 1'b1, 16'h0000, outs(0, 1, 1, 0, 0, 0, 16'hFA5A)};

        repeat (2) @(negedge usb_clk);
        check_reset_outputs("reset");
        check("reset_fifoadr", usb_fifoadr, 2'b00);
        usb_rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            @(negedge usb_clk);
            usb_flag_empty_n = vecs[i].flag;
            bus_gnt          = vecs[i].gnt;
            usb_fd_in        = vecs[i].fd;
            @(posedge usb_clk);
            #1;
            check($sformatf("vec%0d", i),
                  {bus_req, usb_sloe_n, usb_slrd_n, usb_en, usb_wr, cfg_session, usb_data},
                  vecs[i].exp);
        end

        // 300 plain words: the first grant stops at the burst limit.
        bus_gnt = 1'b1;
        sent.delete();
        reset_tracking();
        for (int i = 0; i < 300; i++) push(16'h1000 + 16'(i));
        run_until(300, 2000, "burst");
        check("burst_pulses", pulses, 300);
        check("burst_first_grant", drop_pulses, MAX_BURST);
        check("burst_grants", grants, 2);
        check("burst_data_bad", pulse_bad, 0);
        check("burst_session_bad", sess_bad, 0);

        // Session of 302 words stays within one grant.
        sent.delete();
        reset_tracking();
        push(SYNC_WORD);
        for (int i = 0; i < 300; i++) push(16'h2000 + 16'(i));
        push(UNSYNC_WORD);
        run_until(302, 2000, "session");
        check("session_pulses", pulses, 302);
        check("session_grants", grants, 1);
        check("session_data_bad", pulse_bad, 0);
        check("session_flag_bad", sess_bad, 0);
        check("session_closed", cfg_session, 0);

        // Grant removed during the fifth read strobe.
        sent.delete();
        reset_tracking();
        for (int i = 0; i < 10; i++) push(16'h3000 + 16'(i));
        reads = 0;
        cyc = 0;
        while (reads < 5 && cyc < 200) begin
            step();
            if (!usb_slrd_n) reads++;
            cyc++;
        end
        check("gl_fifth_read", reads, 5);
        bus_gnt = 1'b0;
        lat = 0;
        while (bus_req && lat < 10) begin
            step();
            lat++;
        end
        check("gl_req_low_latency", 32'(lat <= 2), 1);
        repeat (4) step();
        check("gl_pulses", pulses, 5);
        check("gl_data_bad", pulse_bad, 0);

        // Reset in the middle of a read strobe inside a session.
        fifo_q.delete();
        sent.delete();
        rd_seen = 1'b0;
        reset_tracking();
        push(SYNC_WORD);
        for (int i = 0; i < 8; i++) push(16'h4000 + 16'(i));
        bus_gnt = 1'b1;
        reads = 0;
        cyc = 0;
        while (reads < 3 && cyc < 200) begin
            step();
            if (!usb_slrd_n) reads++;
            cyc++;
        end
        check("rst_third_read", reads, 3);
        check("rst_pulses_before", pulses, 2);
        check("rst_session_before", cfg_session, 1);
        usb_rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        rd_seen = 1'b0;
        @(negedge usb_clk);
        usb_rst = 1'b0;
        @(posedge usb_clk);
        #1;
        check("rst_no_en_after_release", usb_en, 0);
        sent = fifo_q;
        reset_tracking();
        run_until(sent.size(), 500, "rst_resume");
        check("rst_resume_pulses", pulses, sent.size());
        check("rst_resume_data_bad", pulse_bad, 0);
        check("rst_resume_session_bad", sess_bad, 0);

        // Lone sync word followed by a long idle period.
        fifo_q.delete();
        sent.delete();
        reset_tracking();
        push(SYNC_WORD);
        run_until(1, 100, "idle_sess");
`ifdef USB_RX_TIMEOUT_EN
        repeat (8) step();
        check("to_session_held", cfg_session, 1);
        repeat (10) step();
        check("to_session_cleared", cfg_session, 0);
        check("to_bus_req", bus_req, 0);
`else
        repeat (40) step();
        check("idle_session_held", cfg_session, 1);
        check("idle_bus_req", bus_req, 0);
        push(UNSYNC_WORD);
        run_until(2, 100, "idle_unsync");
        check("idle_session_closed", cfg_session, 0);
        check("idle_session_bad", sess_bad, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
